// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// Module  : hazard_fwd_ctrl
// Purpose : forwarding-select, load-use stall and branch-flush control for a
//           5-stage pipeline. Optional HAZARD_STATS_EN adds stall/flush counters.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hazard_fwd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       ex_branch_taken,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       idex_bubble,
  output logic       ifid_flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic       idex_valid_q, idex_valid_d;
  logic [4:0] idex_rs1_q, idex_rs1_d;
  logic [4:0] idex_rs2_q, idex_rs2_d;
  logic [4:0] idex_rd_q, idex_rd_d;
  logic       idex_regwrite_q, idex_regwrite_d;
  logic       idex_memread_q, idex_memread_d;
  logic       exmem_valid_q, exmem_valid_d;
  logic [4:0] exmem_rd_q, exmem_rd_d;
  logic       exmem_regwrite_q, exmem_regwrite_d;
  logic       exmem_memread_q, exmem_memread_d;
  logic       memwb_valid_q, memwb_valid_d;
  logic [4:0] memwb_rd_q, memwb_rd_d;
  logic       memwb_regwrite_q, memwb_regwrite_d;

  logic       load_use;
  logic       stall;

  // A load still in EX/MEM has no data yet, so it is excluded from the EX/MEM path.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       em_valid,
    input logic       em_regwrite,
    input logic       em_memread,
    input logic [4:0] em_rd,
    input logic       mw_valid,
    input logic       mw_regwrite,
    input logic [4:0] mw_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (em_valid && em_regwrite && !em_memread && (em_rd != 5'd0) && (em_rd == rs))
      sel = FWD_MEM;
    else if (mw_valid && mw_regwrite && (mw_rd != 5'd0) && (mw_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(idex_rs1_q, exmem_valid_q, exmem_regwrite_q, exmem_memread_q,
                    exmem_rd_q, memwb_valid_q, memwb_regwrite_q, memwb_rd_q);
    fwd_b = fwd_sel(idex_rs2_q, exmem_valid_q, exmem_regwrite_q, exmem_memread_q,
                    exmem_rd_q, memwb_valid_q, memwb_regwrite_q, memwb_rd_q);
  end

  always_comb begin
    load_use = idex_valid_q && idex_memread_q && (idex_rd_q != 5'd0) &&
               ((idex_rd_q == id_rs1) || (idex_rd_q == id_rs2)) && id_valid;
    // A redirect discards the dependent instruction, so it cancels the stall.
    stall         = load_use && !ex_branch_taken;
    pc_write_en   = !stall;
    ifid_write_en = !stall;
    idex_bubble   = stall || ex_branch_taken;
    ifid_flush    = ex_branch_taken;
  end

  always_comb begin
    idex_valid_d    = id_valid;
    idex_rs1_d      = id_rs1;
    idex_rs2_d      = id_rs2;
    idex_rd_d       = id_rd;
    idex_regwrite_d = id_regwrite;
    idex_memread_d  = id_memread;
    if (idex_bubble) begin
      idex_valid_d    = 1'b0;
      idex_rs1_d      = 5'd0;
      idex_rs2_d      = 5'd0;
      idex_rd_d       = 5'd0;
      idex_regwrite_d = 1'b0;
      idex_memread_d  = 1'b0;
    end
    exmem_valid_d    = idex_valid_q;
    exmem_rd_d       = idex_rd_q;
    exmem_regwrite_d = idex_regwrite_q;
    exmem_memread_d  = idex_memread_q;
    memwb_valid_d    = exmem_valid_q;
    memwb_rd_d       = exmem_rd_q;
    memwb_regwrite_d = exmem_regwrite_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_valid_q     <= 1'b0;
      idex_rs1_q       <= 5'd0;
      idex_rs2_q       <= 5'd0;
      idex_rd_q        <= 5'd0;
      idex_regwrite_q  <= 1'b0;
      idex_memread_q   <= 1'b0;
      exmem_valid_q    <= 1'b0;
      exmem_rd_q       <= 5'd0;
      exmem_regwrite_q <= 1'b0;
      exmem_memread_q  <= 1'b0;
      memwb_valid_q    <= 1'b0;
      memwb_rd_q       <= 5'd0;
      memwb_regwrite_q <= 1'b0;
    end else begin
      idex_valid_q     <= idex_valid_d;
      idex_rs1_q       <= idex_rs1_d;
      idex_rs2_q       <= idex_rs2_d;
      idex_rd_q        <= idex_rd_d;
      idex_regwrite_q  <= idex_regwrite_d;
      idex_memread_q   <= idex_memread_d;
      exmem_valid_q    <= exmem_valid_d;
      exmem_rd_q       <= exmem_rd_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      exmem_memread_q  <= exmem_memread_d;
      memwb_valid_q    <= memwb_valid_d;
      memwb_rd_q       <= memwb_rd_d;
      memwb_regwrite_q <= memwb_regwrite_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall)           stall_count_d = stall_count_q + 32'd1;
    if (ex_branch_taken) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
// Module  : tb_hazard_fwd_ctrl
// Purpose : directed scoreboard bench for hazard_fwd_ctrl.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite, id_memread, ex_branch_taken;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_write_en, ifid_write_en, idex_bubble, ifid_flush;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  hazard_fwd_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .pc_write_en     (pc_write_en),
    .ifid_write_en   (ifid_write_en),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  tag;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pw;
    logic        iw;
    logic        bub;
    logic        fl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0]  cyc = 8'd0;
  logic [31:0] exp_sc = 32'd0;
  logic [31:0] exp_fc = 32'd0;

  // Monitor: every cycle the DUT presents a decision; compare against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [5:0] got, want;
      e = sb.pop_front();
      got  = {fwd_a, fwd_b, pc_write_en, ifid_write_en, idex_bubble, ifid_flush};
      want = {e.fa, e.fb, e.pw, e.iw, e.bub, e.fl};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL cyc%0d ctrl {fa,fb,pw,iw,bub,fl}: got %b_%b_%b%b%b%b expected %b_%b_%b%b%b%b",
                 e.tag, fwd_a, fwd_b, pc_write_en, ifid_write_en, idex_bubble, ifid_flush,
                 e.fa, e.fb, e.pw, e.iw, e.bub, e.fl);
      end
`ifdef HAZARD_STATS_EN
      n_cmp++;
      if (stall_count !== e.sc || flush_count !== e.fc) begin
        n_err++;
        $display("FAIL cyc%0d counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.tag, stall_count, flush_count, e.sc, e.fc);
      end
`endif
    end
  end

  // One pipeline cycle: drive inputs, queue the hand-computed response, advance.
  task automatic step(input logic rst, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic br,
                      input logic [1:0] fa, input logic [1:0] fb, input logic pw, input logic iw,
                      input logic bub, input logic fl);
    exp_t e;
    reset = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
    e.tag = cyc; e.fa = fa; e.fb = fb; e.pw = pw; e.iw = iw; e.bub = bub; e.fl = fl;
    e.sc = exp_sc; e.fc = exp_fc;
    sb.push_back(e);
    if (!pw) exp_sc = exp_sc + 32'd1;
    if (fl)  exp_fc = exp_fc + 32'd1;
    if (rst) begin exp_sc = 32'd0; exp_fc = 32'd0; end
    cyc = cyc + 8'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic nop_step(input logic [1:0] fa, input logic [1:0] fb);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, fa, fb, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_regwrite = 1'b0; id_memread = 1'b0; ex_branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    nop_step(2'b00, 2'b00);                                                  // reset values
    // add x5 ; sub x6,x5,x1
    step(0,1, 5'd1,5'd2,5'd5, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd5,5'd1,5'd6, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b10, 2'b00);
    nop_step(2'b00, 2'b00);
    // add x5 ; xor x8,x9,x10 ; or x7,x1,x5
    step(0,1, 5'd1,5'd2,5'd5, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd9,5'd10,5'd8, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd1,5'd5,5'd7, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b00, 2'b01);
    nop_step(2'b00, 2'b00);
    // lw x5 ; add x6,x5,x5 (held in ID during the stall)
    step(0,1, 5'd2,5'd0,5'd5, 1,1,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd5,5'd5,5'd6, 1,0,0, 2'b00,2'b00, 0,0,1,0);
    step(0,1, 5'd5,5'd5,5'd6, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b01, 2'b01);
    nop_step(2'b00, 2'b00);
    // add x0 ; add x3,x0,x0 ; lw x0 ; add x4,x0,x1
    step(0,1, 5'd1,5'd2,5'd0, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd0,5'd0,5'd3, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b00, 2'b00);
    step(0,1, 5'd1,5'd0,5'd0, 1,1,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd0,5'd1,5'd4, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b00, 2'b00);
    nop_step(2'b00, 2'b00);
    // lw x5 ; add x6,x5,x1 arriving with a taken branch
    step(0,1, 5'd2,5'd0,5'd5, 1,1,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd5,5'd1,5'd6, 1,0,1, 2'b00,2'b00, 1,1,1,1);
    nop_step(2'b00, 2'b00);
    nop_step(2'b00, 2'b00);
    // add x5 ; add x5 ; sub x7,x5,x5 -> EX/MEM wins
    step(0,1, 5'd1,5'd2,5'd5, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd3,5'd4,5'd5, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd5,5'd5,5'd7, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b10, 2'b10);
    nop_step(2'b00, 2'b00);
    // lw x5 ; lw x6,(x5) ; add x7,x6,x0 -> two separate one-cycle stalls
    step(0,1, 5'd2,5'd0,5'd5, 1,1,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd5,5'd0,5'd6, 1,1,0, 2'b00,2'b00, 0,0,1,0);
    step(0,1, 5'd5,5'd0,5'd6, 1,1,0, 2'b00,2'b00, 1,1,0,0);
    step(0,1, 5'd6,5'd0,5'd7, 1,0,0, 2'b01,2'b00, 0,0,1,0);
    step(0,1, 5'd6,5'd0,5'd7, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b01, 2'b00);
    nop_step(2'b00, 2'b00);
    // lw x5 ; add x6,x5,x5 with reset asserted in the stall cycle
    step(0,1, 5'd2,5'd0,5'd5, 1,1,0, 2'b00,2'b00, 1,1,0,0);
    step(1,1, 5'd5,5'd5,5'd6, 1,0,0, 2'b00,2'b00, 0,0,1,0);
    n_cmp++;
    if ({dut.idex_valid_q, dut.exmem_valid_q, dut.memwb_valid_q} !== 3'b000) begin
      n_err++;
      $display("FAIL post-reset shadow valid: got %b expected 000",
               {dut.idex_valid_q, dut.exmem_valid_q, dut.memwb_valid_q});
    end
    step(0,1, 5'd5,5'd5,5'd6, 1,0,0, 2'b00,2'b00, 1,1,0,0);
    nop_step(2'b00, 2'b00);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have the ports below; clock and reset come first.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  decode-stage instruction valid.
- id_rs1, id_rs2  input  5 each  decode-stage source register indices.
- id_rd  input  5  decode-stage destination register index.
- id_regwrite  input  1  decode-stage instruction writes rd.
- id_memread  input  1  decode-stage instruction is a load.
- ex_branch_taken  input  1  EX-stage branch/jump redirect.
- fwd_a, fwd_b  output  2 each  select lines for the EX operand 3:1 forwarding muxes.
- pc_write_en, ifid_write_en  output  1 each  pipeline advance enables.
- idex_bubble  output  1  ID/EX register loads a NOP.
- ifid_flush  output  1  IF/ID register loads a NOP.
- stall_count, flush_count  output  32 each  present only with HAZARD_STATS_EN.

Function
REQ-002 The block SHALL keep its own shadow pipeline of three stages: ID/EX {valid, rs1, rs2, rd, regwrite, memread}, EX/MEM {valid, rd, regwrite, memread} and MEM/WB {valid, rd, regwrite}. The shadow stages advance every cycle.
REQ-003 ID/EX SHALL capture the id_* fields when the stage advances normally. It SHALL capture valid=0 when idex_bubble=1.
REQ-004 Forward select encoding SHALL be: 2'b00 = register-file operand, 2'b10 = EX/MEM result, 2'b01 = MEM/WB result. The value 2'b11 SHALL never be driven.
REQ-005 fwd_a SHALL be 2'b10 when EX/MEM.valid & regwrite & rd!=0 & rd==ID/EX.rs1 & !EX/MEM.memread.
- Otherwise fwd_a SHALL be 2'b01 when the same match holds against MEM/WB.
- Otherwise fwd_a SHALL be 2'b00.
- fwd_b SHALL follow the same rules using rs2.
- Both outputs SHALL be combinational from shadow state (zero latency).
REQ-006 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-007 Register x0 SHALL never be forwarded or cause a stall.
REQ-008 A load-use stall SHALL be asserted when ID/EX.valid & memread & rd!=0 & (rd==id_rs1 | rd==id_rs2) & id_valid. During a load-use stall:
- pc_write_en=0, ifid_write_en=0, idex_bubble=1.
- The stall lasts exactly one cycle. The next cycle sees the load in EX/MEM, and the stall is resolved via the MEM/WB forward one cycle later.
REQ-009 A load in EX/MEM matching an ID/EX source SHALL NOT select 2'b10; it falls through to the REQ-005 checks.
REQ-010 On ex_branch_taken=1:
- ifid_flush=1 and idex_bubble=1.
- pc_write_en=1 and ifid_write_en=1, so the redirect target is fetched.
REQ-011 A flush SHALL override a simultaneous load-use stall: no stall is asserted, and the stalled instruction is discarded.
REQ-012 With no hazard: pc_write_en=1, ifid_write_en=1, idex_bubble=0, ifid_flush=0.
REQ-013 Back-to-back loads feeding dependent instructions SHALL each produce exactly one stall cycle. No stall SHALL be held across more than one cycle for a single dependency.

Reset
REQ-014 While reset=1 at a clock edge:
- All shadow valid bits SHALL clear to 0 and all shadow fields to 0.
- Counters SHALL clear to 0.
REQ-015 Outputs SHALL be combinational from shadow state, so after reset they SHALL read: fwd_a=fwd_b=2'b00, pc_write_en=1, ifid_write_en=1, idex_bubble=0, ifid_flush=0.
REQ-016 Reset asserted mid-stall SHALL abandon the stall. The first cycle after reset deasserts SHALL show no hazard.

Configuration
REQ-017 With macro HAZARD_STATS_EN defined, the block SHALL include stall_count and flush_count.
- stall_count increments by 1 per load-use stall cycle.
- flush_count increments by 1 per cycle with ex_branch_taken=1.
- Both wrap from 32'hFFFFFFFF to 0.
REQ-018 Without HAZARD_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-019 Scenario 1: add x5 then sub x6,x5,x1 back-to-back -> the cycle sub is in EX shows fwd_a=2'b10 and fwd_b=2'b00.
REQ-020 Scenario 2: add x5, one unrelated instruction, then or x7,x1,x5 -> fwd_b=2'b01 while or is in EX.
REQ-021 Scenario 3: lw x5 then add x6,x5,x5 -> one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1; next EX cycle shows fwd_a=fwd_b=2'b01; stall_count=1.
REQ-022 Scenario 4: add x0 then add x3,x0,x0 -> fwd_a=fwd_b=2'b00 and no stall.
REQ-023 Scenario 5: a load-use hazard coincident with ex_branch_taken=1 -> ifid_flush=1, idex_bubble=1, pc_write_en=1; stall_count unchanged; flush_count+1.
REQ-024 Scenario 6: reset asserted during a stall cycle, then released -> outputs take the REQ-015 values, and valid is 0 in all shadow stages.
